montgomery_power_selector: RTL and testbench

Consumes the block stream of successive Montgomery squares produced by the squarer stage. The stream carries x, x^2, x^4, … x^(2^(BITS_IN_NUM-1)), each in Montgomery form. The block forwards only the powers whose matching exponent bit is set, with per-number framing, so the downstream Montgomery accumulator-multiplier can fold them into the modular-exponentiation result. The exponent is streamed in beforehand, one register-sized word at a time, LSB word first.

---
 rtl/montgomery_power_selector.sv | 181 ++++++++++++++++++
 tb/tb_montgomery_power_selector.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_power_selector.sv
// -----------------------------------------------------------------------------
// montgomery_power_selector
//
// Filters the squarer's stream of successive Montgomery squares
// (x, x^2, x^4, ... x^(2^(BITS_IN_NUM-1))) down to the powers whose matching
// exponent bit is set, framing each forwarded number with a last flag so the
// downstream accumulator-multiplier can fold it into the exponentiation result.
//
// The exponent is streamed in first, one REGISTER_SIZE word at a time, LSB
// word first. During the run the stored exponent acts as a shift register:
// bit 0 selects the current power and it shifts right on every number wrap.
//
// Optional feature macro: POWER_SELECTOR_FIRST_FLAG_EN
//   When defined, adds selected_first_out, high on every block of the first
//   forwarded number of a run so the accumulator loads instead of multiplying.
//
// Ports
//   clk_in              clock, single domain
//   rst_in              synchronous active-high reset
//   exponent_block_in   exponent word, LSB word first
//   exponent_valid_in   exponent word valid
//   exponent_ready_out  high while exponent words are accepted (IDLE/LOAD)
//   squared_block_in    squarer output block, LSB block first
//   squared_valid_in    squarer block valid, no backpressure
//   selected_block_out  forwarded block (1-cycle registered latency)
//   selected_valid_out  forwarded block valid
//   selected_last_out   final block of a forwarded number
//   done_out            one-cycle pulse after the last block of the last power
//   error_out           sticky: squared block seen outside RUN
//   selected_first_out  (optional) block belongs to first forwarded number
// -----------------------------------------------------------------------------
module montgomery_power_selector #(
    parameter int REGISTER_SIZE  = 32,
    parameter int BITS_IN_NUM    = 2048,
    parameter int BLOCKS_PER_NUM = 2 * BITS_IN_NUM / REGISTER_SIZE
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [REGISTER_SIZE-1:0] exponent_block_in,
    input  logic                     exponent_valid_in,
    output logic                     exponent_ready_out,
    input  logic [REGISTER_SIZE-1:0] squared_block_in,
    input  logic                     squared_valid_in,
    output logic [REGISTER_SIZE-1:0] selected_block_out,
    output logic                     selected_valid_out,
    output logic                     selected_last_out,
    output logic                     done_out,
    output logic                     error_out
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
    ,
    output logic                     selected_first_out
`endif
);

    localparam int WORDS  = BITS_IN_NUM / REGISTER_SIZE;
    localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BLK_W  = (BLOCKS_PER_NUM > 1) ? $clog2(BLOCKS_PER_NUM) : 1;
    localparam int PWR_W  = $clog2(BITS_IN_NUM) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                 state;
    logic [BITS_IN_NUM-1:0] exp_reg;
    logic [WORD_W-1:0]      word_ctr;
    logic [BLK_W-1:0]       block_ctr;
    logic [PWR_W-1:0]       power_ctr;

    logic number_wrap;
    assign number_wrap = (block_ctr == BLK_W'(BLOCKS_PER_NUM - 1));

`ifdef POWER_SELECTOR_FIRST_FLAG_EN
    // Stays set until the first number with a set exponent bit has passed.
    logic first_pending;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            // NOTE: the exponent register is reset too, so a load aborted by
            // reset never leaks stale bits into the next run.
            state              <= ST_IDLE;
            exp_reg            <= '0;
            word_ctr           <= '0;
            block_ctr          <= '0;
            power_ctr          <= '0;
            exponent_ready_out <= 1'b0;
            selected_block_out <= '0;
            selected_valid_out <= 1'b0;
            selected_last_out  <= 1'b0;
            done_out           <= 1'b0;
            error_out          <= 1'b0;
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
            first_pending      <= 1'b0;
            selected_first_out <= 1'b0;
`endif
        end else begin
            // NOTE: all state uses non-blocking assignments so every branch
            // below sees the pre-edge values; these defaults make the strobes
            // single-cycle unless a branch re-asserts them.
            selected_valid_out <= 1'b0;
            selected_last_out  <= 1'b0;
            done_out           <= 1'b0;
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
            selected_first_out <= 1'b0;
`endif

            case (state)
                ST_IDLE, ST_LOAD: begin
                    exponent_ready_out <= 1'b1;
                    // Acceptance follows the registered ready, so the cycle
                    // right after reset never takes a word.
                    if (exponent_valid_in && exponent_ready_out) begin
                        exp_reg[word_ctr * REGISTER_SIZE +: REGISTER_SIZE] <= exponent_block_in;
                        if (word_ctr == WORD_W'(WORDS - 1)) begin
                            state              <= ST_RUN;
                            exponent_ready_out <= 1'b0;
                            word_ctr           <= '0;
                            block_ctr          <= '0;
                            power_ctr          <= '0;
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
                            first_pending      <= 1'b1;
`endif
                        end else begin
                            state    <= ST_LOAD;
                            word_ctr <= word_ctr + 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    exponent_ready_out <= 1'b0;
                    if (squared_valid_in) begin
                        if (exp_reg[0]) begin
                            selected_block_out <= squared_block_in;
                            selected_valid_out <= 1'b1;
                            selected_last_out  <= number_wrap;
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
                            selected_first_out <= first_pending;
`endif
                        end
                        if (number_wrap) begin
                            block_ctr <= '0;
                            power_ctr <= power_ctr + 1'b1;
                            exp_reg   <= exp_reg >> 1;
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
                            if (exp_reg[0]) begin
                                first_pending <= 1'b0;
                            end
`endif
                            if (power_ctr == PWR_W'(BITS_IN_NUM - 1)) begin
                                state    <= ST_DONE;
                                done_out <= 1'b1;
                            end
                        end else begin
                            block_ctr <= block_ctr + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state              <= ST_IDLE;
                    exponent_ready_out <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Blocks arriving outside RUN are dropped and flagged until reset.
            if (squared_valid_in && (state != ST_RUN)) begin
                error_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_montgomery_power_selector.sv
// -----------------------------------------------------------------------------
// Testbench for montgomery_power_selector with REGISTER_SIZE=8, BITS_IN_NUM=16,
// BLOCKS_PER_NUM=4. Input block value = power index*16 + block index.
// -----------------------------------------------------------------------------
module tb_montgomery_power_selector;

    localparam int RS   = 8;
    localparam int BITS = 16;
    localparam int BPN  = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [RS-1:0] exponent_block_in;
    logic          exponent_valid_in;
    logic          exponent_ready_out;
    logic [RS-1:0] squared_block_in;
    logic          squared_valid_in;
    logic [RS-1:0] selected_block_out;
    logic          selected_valid_out;
    logic          selected_last_out;
    logic          done_out;
    logic          error_out;
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
    logic          selected_first_out;
`endif

    montgomery_power_selector #(
        .REGISTER_SIZE (RS),
        .BITS_IN_NUM   (BITS),
        .BLOCKS_PER_NUM(BPN)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .exponent_block_in (exponent_block_in),
        .exponent_valid_in (exponent_valid_in),
        .exponent_ready_out(exponent_ready_out),
        .squared_block_in  (squared_block_in),
        .squared_valid_in  (squared_valid_in),
        .selected_block_out(selected_block_out),
        .selected_valid_out(selected_valid_out),
        .selected_last_out (selected_last_out),
        .done_out          (done_out),
        .error_out         (error_out)
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
        ,
        .selected_first_out(selected_first_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] expo;
        int          gap;
        int          fwd_count;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ready"},  {31'd0, exponent_ready_out}, 32'd0);
        check({tag, " valid"},  {31'd0, selected_valid_out}, 32'd0);
        check({tag, " last"},   {31'd0, selected_last_out},  32'd0);
        check({tag, " done"},   {31'd0, done_out},           32'd0);
        check({tag, " error"},  {31'd0, error_out},          32'd0);
        check({tag, " block"},  {24'd0, selected_block_out}, 32'd0);
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
        check({tag, " first"},  {31'd0, selected_first_out}, 32'd0);
`endif
    endtask

    task automatic load_exp(input logic [15:0] expo);
        int waited = 0;
        while (!exponent_ready_out && waited < 20) begin
            step();
            waited++;
        end
        check("load ready wait", {31'd0, exponent_ready_out}, 32'd1);
        exponent_valid_in = 1'b1;
        exponent_block_in = expo[7:0];
        step();
        exponent_block_in = expo[15:8];
        step();
        exponent_valid_in = 1'b0;
        exponent_block_in = '0;
        check("ready low in run", {31'd0, exponent_ready_out}, 32'd0);
    endtask

    // Feed n_pow numbers of BPN blocks, checking each forwarded block one
    // cycle after its input against the exponent bit for that power.
    task automatic run_blocks(input logic [15:0] expo, input int gap, input int n_pow,
                              input logic exp_err, output int fwd);
        int lowest = -1;
        for (int i = 0; i < BITS; i++) begin
            if (expo[i] && lowest < 0) lowest = i;
        end
        fwd = 0;
        for (int p = 0; p < n_pow; p++) begin
            for (int b = 0; b < BPN; b++) begin
                logic want;
                want = expo[p];
                squared_valid_in = 1'b1;
                squared_block_in = 8'(p * 16 + b);
                step();
                squared_valid_in = 1'b0;
                squared_block_in = '0;
                check($sformatf("valid p%0d b%0d", p, b), {31'd0, selected_valid_out}, {31'd0, want});
                if (selected_valid_out) fwd++;
                if (want) begin
                    check($sformatf("block p%0d b%0d", p, b), {24'd0, selected_block_out}, 32'(p * 16 + b));
                    check($sformatf("last p%0d b%0d", p, b), {31'd0, selected_last_out}, (b == BPN - 1) ? 32'd1 : 32'd0);
`ifdef POWER_SELECTOR_FIRST_FLAG_EN
                    check($sformatf("first p%0d b%0d", p, b), {31'd0, selected_first_out}, (p == lowest) ? 32'd1 : 32'd0);
`endif
                end
                check($sformatf("done p%0d b%0d", p, b), {31'd0, done_out},
                      (p == BITS - 1 && b == BPN - 1) ? 32'd1 : 32'd0);
                for (int g = 0; g < gap; g++) begin
                    step();
                    check($sformatf("gap valid p%0d b%0d", p, b), {31'd0, selected_valid_out}, 32'd0);
                    check($sformatf("gap done p%0d b%0d", p, b), {31'd0, done_out}, 32'd0);
                end
            end
        end
        if (n_pow == BITS) begin
            step();
            check("done single pulse", {31'd0, done_out}, 32'd0);
            check("ready after done", {31'd0, exponent_ready_out}, 32'd1);
        end
        check("error state", {31'd0, error_out}, {31'd0, exp_err});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int fwd;

        vecs[0] = '{expo: 16'h8005, gap: 0, fwd_count: 12};
        vecs[1] = '{expo: 16'h0000, gap: 0, fwd_count: 0};
        vecs[2] = '{expo: 16'hFFFF, gap: 3, fwd_count: 64};
        vecs[3] = '{expo: 16'h000A, gap: 0, fwd_count: 8};

        rst_in            = 1'b1;
        exponent_block_in = '0;
        exponent_valid_in = 1'b0;
        squared_block_in  = '0;
        squared_valid_in  = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_in = 1'b0;
        step();
        check("ready after reset", {31'd0, exponent_ready_out}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            load_exp(vecs[i].expo);
            run_blocks(vecs[i].expo, vecs[i].gap, BITS, 1'b0, fwd);
            check($sformatf("fwd count vec%0d", i), 32'(fwd), 32'(vecs[i].fwd_count));
        end

        // Squared block while IDLE: dropped, error raised and held.
        squared_valid_in = 1'b1;
        squared_block_in = 8'h55;
        step();
        squared_valid_in = 1'b0;
        squared_block_in = '0;
        check("idle block dropped", {31'd0, selected_valid_out}, 32'd0);
        check("idle error set", {31'd0, error_out}, 32'd1);
        step();
        check("idle error held", {31'd0, error_out}, 32'd1);
        load_exp(16'h0001);
        run_blocks(16'h0001, 0, BITS, 1'b1, fwd);
        check("fwd count after error", 32'(fwd), 32'd4);

        // Reset after power 5 aborts the run without a done pulse.
        load_exp(16'h0002);
        run_blocks(16'h0002, 0, 6, 1'b1, fwd);
        check("fwd count partial", 32'(fwd), 32'd4);
        rst_in = 1'b1;
        step();
        check_all_zero("mid-run reset");
        rst_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("no done after reset c%0d", c), {31'd0, done_out}, 32'd0);
            check($sformatf("no valid after reset c%0d", c), {31'd0, selected_valid_out}, 32'd0);
        end
        load_exp(16'h0002);
        run_blocks(16'h0002, 0, BITS, 1'b0, fwd);
        check("fwd count reload", 32'(fwd), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
